// File: rtl/bus_write_checker.sv
// Ordered bus-write scoreboard: compares CPU write cycles against a table of
// expected {address, data} entries and reports pass, fail or timeout.
module bus_write_checker #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int PTR_W   = 3,
  parameter int TIMEOUT = 256,
  parameter int STRICT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic              bus_valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] odata,
  input  logic              rw,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        fail_code,
  output logic [PTR_W-1:0]  fail_idx,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [PTR_W:0]    match_count,
  output logic              overflow
);

  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 2);
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W+1)'(DEPTH);
  localparam logic             STRICT_C  = (STRICT != 0);

  localparam logic [1:0] CODE_DATA = 2'b01;
  localparam logic [1:0] CODE_UNEX = 2'b10;
  localparam logic [1:0] CODE_TMO  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PASS  = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   tab_addr_r [DEPTH];
  logic [DATA_W-1:0]   tab_data_r [DEPTH];
  logic [PTR_W:0]      count_r;
  logic [PTR_W-1:0]    rd_r;
  logic [TMO_W-1:0]    tmo_r;

  logic                full_s;
  logic                load_ok_s;
  logic                tab_we_s;
  logic [PTR_W:0]      count_next_s;
  logic                wr_s;
  logic                addr_hit_s;
  logic                match_s;
  logic                last_s;
  logic                tmo_hit_s;

  // Head-entry comparison, load acceptance and timeout detection.
  always_comb begin
    full_s       = (count_r == DEPTH_C);
    load_ok_s    = load_en && !full_s;
    tab_we_s     = (state_r == ST_IDLE) && !clear && load_ok_s;
    count_next_s = count_r + {{PTR_W{1'b0}}, load_ok_s};
    wr_s         = bus_valid && !rw;
    addr_hit_s   = wr_s && (addr == tab_addr_r[rd_r]);
    match_s      = addr_hit_s && (odata == tab_data_r[rd_r]);
    last_s       = ((match_count + {{PTR_W{1'b0}}, 1'b1}) == count_r);
    tmo_hit_s    = (tmo_r == TMO_LAST);
  end

  // Expected-write table storage; contents survive clear and reset by design.
  always_ff @(posedge clk) begin
    if (tab_we_s) begin
      tab_addr_r[count_r[PTR_W-1:0]] <= load_addr;
      tab_data_r[count_r[PTR_W-1:0]] <= load_data;
    end else begin
      tab_addr_r[count_r[PTR_W-1:0]] <= tab_addr_r[count_r[PTR_W-1:0]];
      tab_data_r[count_r[PTR_W-1:0]] <= tab_data_r[count_r[PTR_W-1:0]];
    end
  end

  // Checker state machine with registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      count_r     <= '0;
      rd_r        <= '0;
      tmo_r       <= '0;
      busy        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_code   <= 2'b00;
      fail_idx    <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else if (clear) begin
      state_r     <= ST_IDLE;
      count_r     <= '0;
      rd_r        <= '0;
      tmo_r       <= '0;
      busy        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_code   <= 2'b00;
      fail_idx    <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (load_en && full_s) begin
            overflow <= 1'b1;
          end else begin
            overflow <= overflow;
          end
          count_r <= count_next_s;
          // start sees the count including a load taken in the same cycle
          if (start && (count_next_s == '0)) begin
            state_r <= ST_PASS;
            pass    <= 1'b1;
          end else if (start) begin
            state_r     <= ST_ARMED;
            busy        <= 1'b1;
            rd_r        <= '0;
            tmo_r       <= '0;
            match_count <= '0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (match_s) begin
            rd_r        <= rd_r + {{(PTR_W-1){1'b0}}, 1'b1};
            match_count <= match_count + {{PTR_W{1'b0}}, 1'b1};
            tmo_r       <= '0;
            if (last_s) begin
              state_r <= ST_PASS;
              busy    <= 1'b0;
              pass    <= 1'b1;
            end else begin
              state_r <= ST_ARMED;
            end
          end else if (addr_hit_s) begin
            state_r   <= ST_FAIL;
            busy      <= 1'b0;
            fail      <= 1'b1;
            fail_code <= CODE_DATA;
            fail_idx  <= rd_r;
            fail_addr <= addr;
            fail_data <= odata;
          end else if (wr_s && STRICT_C) begin
            state_r   <= ST_FAIL;
            busy      <= 1'b0;
            fail      <= 1'b1;
            fail_code <= CODE_UNEX;
            fail_idx  <= rd_r;
            fail_addr <= addr;
            fail_data <= odata;
          end else if (tmo_hit_s) begin
            state_r   <= ST_FAIL;
            busy      <= 1'b0;
            fail      <= 1'b1;
            fail_code <= CODE_TMO;
            fail_idx  <= rd_r;
            fail_addr <= '0;
            fail_data <= '0;
          end else begin
            tmo_r <= tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
          end
        end
        ST_PASS: begin
          state_r <= ST_PASS;
        end
        ST_FAIL: begin
          state_r <= ST_FAIL;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
